// File: rtl/shared_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_counter_pkg
// Purpose  : Shared command encoding and controller state type for the
//            shared counter controller and the subcounter slices it drives.
// Revision : 1.0  initial release
// ============================================================================
package shared_counter_pkg;

  // Per-slice 2-bit command codes (11 is unused and decodes as idle)
  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_INC   = 2'b01;
  localparam logic [1:0] CMD_IDLE  = 2'b10;

  // Controller states
  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  // Map a slice increment enable onto its command code
  function automatic logic [1:0] slice_cmd(input logic inc_en);
    return inc_en ? CMD_INC : CMD_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_counter_ctrl_carry.sv
`default_nettype none
// ============================================================================
// Module   : slice_carry_chain
// Purpose  : Per-slice all-ones detect over the shadow count and a prefix-AND
//            that yields one increment enable per slice, plus a whole-counter
//            all-ones flag used for wrap and saturation decisions.
// Revision : 1.0  initial release
// ============================================================================
module slice_carry_chain #(
  parameter int GRANULARITY = 4,
  parameter int NUM_SLICES  = 4
) (
  input  logic [GRANULARITY*NUM_SLICES-1:0] i_shadow,
  output logic [NUM_SLICES-1:0]             o_inc_en,
  output logic                              o_all_ones
);

  logic [NUM_SLICES-1:0] w_slice_ones;

  genvar k;
  generate
    for (k = 0; k < NUM_SLICES; k++) begin : g_slice
      assign w_slice_ones[k] = &i_shadow[k*GRANULARITY +: GRANULARITY];

      // Slice 0 always counts; slice k counts only when every lower slice is full.
      // Each enable is a flat reduction so no bit depends on another enable bit.
      if (k == 0) begin : g_lsb
        assign o_inc_en[k] = 1'b1;
      end else begin : g_upper
        assign o_inc_en[k] = &w_slice_ones[k-1:0];
      end
    end
  endgenerate

  assign o_all_ones = &w_slice_ones;

endmodule
`default_nettype wire

// File: rtl/shared_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shared_counter_ctrl
// Purpose  : Upstream command generator for a chain of subcounter slices that
//            together form one WIDTH-bit counter. Accepts clear/increment
//            requests, issues one registered command per slice with carries
//            resolved from a shadow copy, checks the slices against the shadow,
//            flags overflow and optionally saturates.
// Revision : 1.0  initial release
// ============================================================================
module shared_counter_ctrl
  import shared_counter_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int GRANULARITY = 4,
  parameter  int SATURATE    = 0,
  localparam int NUM_SLICES  = WIDTH / GRANULARITY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_op,
  output logic                    req_ready,
  output logic [2*NUM_SLICES-1:0] sub_cmd_out,
  input  logic [WIDTH-1:0]        slice_data_in,
  output logic [WIDTH-1:0]        count_out,
  output logic                    overflow,
  output logic                    mismatch
);

  localparam int CMDW = 2 * NUM_SLICES;

  // FSM
  state_t              r_state;
  state_t              w_state_nxt;

  // Command / shadow datapath
  logic [CMDW-1:0]       r_cmd;
  logic [CMDW-1:0]       w_cmd_nxt;
  logic [WIDTH-1:0]      r_count;
  logic [WIDTH-1:0]      w_count_nxt;
  logic [WIDTH-1:0]      w_count_inc;
  logic                  r_overflow;
  logic                  w_overflow_nxt;

  // Checker
  logic [WIDTH-1:0]      r_exp;
  logic                  r_chk_en;
  logic                  r_mismatch;

  // Decode helpers
  logic [NUM_SLICES-1:0] w_inc_en;
  logic                  w_all_ones;
  logic                  w_accept;
  logic                  w_do_inc;
  logic                  w_do_clr;
  logic                  w_inc_max;
  logic                  w_hold;

  slice_carry_chain #(
    .GRANULARITY (GRANULARITY),
    .NUM_SLICES  (NUM_SLICES)
  ) u_carry (
    .i_shadow   (r_count),
    .o_inc_en   (w_inc_en),
    .o_all_ones (w_all_ones)
  );

  assign w_accept    = req_valid & req_ready;
  assign w_do_clr    = w_accept & req_op;
  assign w_do_inc    = w_accept & ~req_op;
  assign w_count_inc = r_count + WIDTH'(1);
  assign w_inc_max   = &w_count_inc;
  // In saturating builds a full counter, or the SAT state, freezes increments.
  assign w_hold      = (SATURATE != 0) && ((r_state == SAT) || w_all_ones);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: INIT lasts one cycle; SAT is entered by the increment reaching all-ones
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT: w_state_nxt = RUN;
      RUN: begin
        if (w_do_inc && (SATURATE != 0) && (w_inc_max || w_all_ones)) begin
          w_state_nxt = SAT;
        end
      end
      SAT: begin
        if (w_do_clr) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // FSM outputs: requests are taken in every state except INIT
  always_comb begin
    req_ready = (r_state == RUN) || (r_state == SAT);
  end

  // Next command, shadow count and overflow for the request (if any) accepted this cycle
  always_comb begin
    w_cmd_nxt      = {NUM_SLICES{CMD_IDLE}};
    w_count_nxt    = r_count;
    w_overflow_nxt = 1'b0;
    if (w_do_clr) begin
      w_cmd_nxt   = {NUM_SLICES{CMD_RESET}};
      w_count_nxt = '0;
    end else if (w_do_inc && !w_hold) begin
      for (int k = 0; k < NUM_SLICES; k++) begin
        w_cmd_nxt[2*k +: 2] = slice_cmd(w_inc_en[k]);
      end
      w_count_nxt    = w_count_inc;
      // Wrapping build: pulse on all-ones -> zero. Saturating build: pulse on reaching all-ones.
      w_overflow_nxt = (SATURATE == 0) ? w_all_ones : w_inc_max;
    end
  end

  // Command, shadow and overflow registers; reset drives CMD_RESET so slices clear while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= {NUM_SLICES{CMD_RESET}};
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cmd      <= w_cmd_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Checker: shadow delayed one edge lines up with the slices applying the command; mismatch is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp      <= '0;
      r_chk_en   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_exp      <= r_count;
      r_chk_en   <= r_chk_en | (r_state != INIT);
      r_mismatch <= r_mismatch | (r_chk_en & (slice_data_in != r_exp));
    end
  end

  assign sub_cmd_out = r_cmd;
  assign count_out   = r_count;
  assign overflow    = r_overflow;
  assign mismatch    = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_shared_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_counter_ctrl
// Purpose  : Self-checking bench for shared_counter_ctrl. Two controllers
//            (wrapping and saturating) each drive four 4-bit subcounter models;
//            a reference model pushes expected results into per-DUT queues
//            that are popped after each clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_shared_counter_ctrl;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NS = W / G;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic v0 = 1'b0, op0 = 1'b0, v1 = 1'b0, op1 = 1'b0;
  logic rdy0, rdy1, ovf0, ovf1, mm0, mm1;
  logic [2*NS-1:0] cmd0, cmd1;
  logic [W-1:0] cnt0, cnt1, slc0, slc1, din0, din1;
  logic [W-1:0] corrupt0 = '0;

  always #5 clk = ~clk;

  assign din0 = slc0 ^ corrupt0;
  assign din1 = slc1;

  shared_counter_ctrl #(.WIDTH(W), .GRANULARITY(G), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_op(op0), .req_ready(rdy0),
    .sub_cmd_out(cmd0), .slice_data_in(din0), .count_out(cnt0),
    .overflow(ovf0), .mismatch(mm0)
  );

  shared_counter_ctrl #(.WIDTH(W), .GRANULARITY(G), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_op(op1), .req_ready(rdy1),
    .sub_cmd_out(cmd1), .slice_data_in(din1), .count_out(cnt1),
    .overflow(ovf1), .mismatch(mm1)
  );

  // Four subcounter slices per controller: 00 clear, 01 increment, else hold
  always_ff @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      case (cmd0[2*k +: 2])
        2'b00:   slc0[G*k +: G] <= '0;
        2'b01:   slc0[G*k +: G] <= slc0[G*k +: G] + 4'h1;
        default: ;
      endcase
      case (cmd1[2*k +: 2])
        2'b00:   slc1[G*k +: G] <= '0;
        2'b01:   slc1[G*k +: G] <= slc1[G*k +: G] + 4'h1;
        default: ;
      endcase
    end
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2*NS-1:0] cmd;
    logic [W-1:0]    cnt;
    logic            ovf;
    logic [W-1:0]    slc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state
  logic [W-1:0] m_cnt0 = '0;
  logic [W-1:0] m_cnt1 = '0;
  logic         m_sat1 = 1'b0;

  // Expected command byte: slice k increments iff all bits below it are ones
  function automatic logic [2*NS-1:0] model_cmd(input logic [W-1:0] cnt, input logic v,
                                                input logic op, input logic hold);
    logic [2*NS-1:0] c;
    logic [31:0]     m;
    if (!v)   return 8'hAA;
    if (op)   return 8'h00;
    if (hold) return 8'hAA;
    c = '0;
    for (int k = 0; k < NS; k++) begin
      m = (32'd1 << (G * k)) - 32'd1;
      c[2*k +: 2] = ((cnt & m[W-1:0]) == m[W-1:0]) ? 2'b01 : 2'b10;
    end
    return c;
  endfunction

  // One clock of stimulus for both DUTs; expectations are queued, then checked after the edge
  task automatic step(input logic a_v0, input logic a_op0, input logic a_v1, input logic a_op1);
    exp_t e0, e1, g0, g1;
    e0.slc = m_cnt0;
    e1.slc = m_cnt1;
    e0.cmd = model_cmd(m_cnt0, a_v0, a_op0, 1'b0);
    e1.cmd = model_cmd(m_cnt1, a_v1, a_op1, m_sat1);
    e0.ovf = 1'b0;
    e1.ovf = 1'b0;
    if (a_v0) begin
      if (a_op0) begin
        m_cnt0 = '0;
      end else begin
        e0.ovf = (m_cnt0 == 16'hFFFF);
        m_cnt0 = m_cnt0 + 16'd1;
      end
    end
    if (a_v1) begin
      if (a_op1) begin
        m_cnt1 = '0;
        m_sat1 = 1'b0;
      end else if (!m_sat1) begin
        m_cnt1 = m_cnt1 + 16'd1;
        if (m_cnt1 == 16'hFFFF) begin
          m_sat1 = 1'b1;
          e1.ovf = 1'b1;
        end
      end
    end
    e0.cnt = m_cnt0;
    e1.cnt = m_cnt1;
    q0.push_back(e0);
    q1.push_back(e1);
    v0 = a_v0; op0 = a_op0; v1 = a_v1; op1 = a_op1;
    @(posedge clk);
    #1;
    g0 = q0.pop_front();
    g1 = q1.pop_front();
    checks++; if (cmd0 !== g0.cmd) begin failures++; $display("FAIL dut0_cmd t=%0t: got %h expected %h", $time, cmd0, g0.cmd); end
    checks++; if (cnt0 !== g0.cnt) begin failures++; $display("FAIL dut0_count t=%0t: got %h expected %h", $time, cnt0, g0.cnt); end
    checks++; if (ovf0 !== g0.ovf) begin failures++; $display("FAIL dut0_overflow t=%0t: got %b expected %b", $time, ovf0, g0.ovf); end
    checks++; if (slc0 !== g0.slc) begin failures++; $display("FAIL dut0_slices t=%0t: got %h expected %h", $time, slc0, g0.slc); end
    checks++; if (cmd1 !== g1.cmd) begin failures++; $display("FAIL dut1_cmd t=%0t: got %h expected %h", $time, cmd1, g1.cmd); end
    checks++; if (cnt1 !== g1.cnt) begin failures++; $display("FAIL dut1_count t=%0t: got %h expected %h", $time, cnt1, g1.cnt); end
    checks++; if (ovf1 !== g1.ovf) begin failures++; $display("FAIL dut1_overflow t=%0t: got %b expected %b", $time, ovf1, g1.ovf); end
    checks++; if (slc1 !== g1.slc) begin failures++; $display("FAIL dut1_slices t=%0t: got %h expected %h", $time, slc1, g1.slc); end
  endtask

  // Apply reset, release it, and check the INIT cycle and the first RUN cycles
  task automatic test_reset();
    v0 = 1'b0; op0 = 1'b0; v1 = 1'b0; op1 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd0 !== 8'h00) begin failures++; $display("FAIL rst_cmd0: got %h expected 00", cmd0); end
    checks++; if (cnt0 !== 16'h0) begin failures++; $display("FAIL rst_count0: got %h expected 0000", cnt0); end
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL rst_ready0: got %b expected 0", rdy0); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL rst_overflow0: got %b expected 0", ovf0); end
    checks++; if (mm0 !== 1'b0) begin failures++; $display("FAIL rst_mismatch0: got %b expected 0", mm0); end
    checks++; if (cmd1 !== 8'h00) begin failures++; $display("FAIL rst_cmd1: got %h expected 00", cmd1); end
    checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL rst_ready1: got %b expected 0", rdy1); end
    rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL init_ready0: got %b expected 0", rdy0); end
    checks++; if (cmd0 !== 8'h00) begin failures++; $display("FAIL init_cmd0: got %h expected 00", cmd0); end
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL run_ready0: got %b expected 1", rdy0); end
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL run_ready1: got %b expected 1", rdy1); end
    checks++; if (cmd0 !== 8'hAA) begin failures++; $display("FAIL init_exit_cmd0: got %h expected AA", cmd0); end
    checks++; if (cnt0 !== 16'h0) begin failures++; $display("FAIL init_exit_count0: got %h expected 0000", cnt0); end
    m_cnt0 = '0; m_cnt1 = '0; m_sat1 = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (mm0 !== 1'b0) begin failures++; $display("FAIL post_rst_mismatch0: got %b expected 0", mm0); end
    checks++; if (mm1 !== 1'b0) begin failures++; $display("FAIL post_rst_mismatch1: got %b expected 0", mm1); end
  endtask

  // Back-to-back increments across the first inter-slice carry, plus op ignored when not valid
  task automatic test_back_to_back();
    repeat (15) step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (cnt0 !== 16'h000F) begin failures++; $display("FAIL b2b_count15: got %h expected 000F", cnt0); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (cmd0 !== 8'hA5) begin failures++; $display("FAIL b2b_carry_cmd: got %h expected A5", cmd0); end
    checks++; if (cnt0 !== 16'h0010) begin failures++; $display("FAIL b2b_count16: got %h expected 0010", cnt0); end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (slc0 !== 16'h0010) begin failures++; $display("FAIL b2b_slices: got %h expected 0010", slc0); end
  endtask

  // Walk both counters up to FFFE by increments
  task automatic test_preload();
    while (m_cnt0 != 16'hFFFE) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (slc0 !== 16'hFFFE) begin failures++; $display("FAIL preload_slices0: got %h expected FFFE", slc0); end
    checks++; if (cnt1 !== 16'hFFFE) begin failures++; $display("FAIL preload_count1: got %h expected FFFE", cnt1); end
  endtask

  // Wrap on dut0, saturate then clear on dut1
  task automatic test_wrap_saturate();
    int n_ovf1 = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    if (ovf1 === 1'b1) n_ovf1++;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    if (ovf1 === 1'b1) n_ovf1++;
    checks++; if (cmd0 !== 8'h55) begin failures++; $display("FAIL wrap_cmd: got %h expected 55", cmd0); end
    checks++; if (cnt0 !== 16'h0000) begin failures++; $display("FAIL wrap_count: got %h expected 0000", cnt0); end
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL wrap_overflow: got %b expected 1", ovf0); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    if (ovf1 === 1'b1) n_ovf1++;
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL wrap_overflow_pulse: got %b expected 0", ovf0); end
    checks++; if (cnt1 !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %h expected FFFF", cnt1); end
    checks++; if (n_ovf1 != 1) begin failures++; $display("FAIL sat_overflow_count: got %0d expected 1", n_ovf1); end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (cnt1 !== 16'h0000) begin failures++; $display("FAIL sat_clear: got %h expected 0000", cnt1); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cnt1 !== 16'h0001) begin failures++; $display("FAIL sat_run_after_clear: got %h expected 0001", cnt1); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Corrupt slice 2 of dut0 for one cycle; mismatch must rise and stick
  task automatic test_mismatch();
    checks++; if (mm0 !== 1'b0) begin failures++; $display("FAIL mm_before: got %b expected 0", mm0); end
    corrupt0 = 16'h0500;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    corrupt0 = '0;
    checks++; if (mm0 !== 1'b1) begin failures++; $display("FAIL mm_rise: got %b expected 1", mm0); end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (mm0 !== 1'b1) begin failures++; $display("FAIL mm_sticky: got %b expected 1", mm0); end
    checks++; if (mm1 !== 1'b0) begin failures++; $display("FAIL mm_other: got %b expected 0", mm1); end
  endtask

  // Count to 0123 then drop reset between edges with a command in flight
  task automatic test_reset_midstream();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    while (m_cnt0 != 16'h0123) step(1'b1, 1'b0, 1'b1, 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cmd0 !== 8'h00) begin failures++; $display("FAIL async_cmd0: got %h expected 00", cmd0); end
    checks++; if (cnt0 !== 16'h0) begin failures++; $display("FAIL async_count0: got %h expected 0000", cnt0); end
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL async_ready0: got %b expected 0", rdy0); end
    checks++; if (mm0 !== 1'b0) begin failures++; $display("FAIL async_mismatch0: got %b expected 0", mm0); end
    checks++; if (cnt1 !== 16'h0) begin failures++; $display("FAIL async_count1: got %h expected 0000", cnt1); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_cnt0 = '0; m_cnt1 = '0; m_sat1 = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (slc0 !== 16'h0) begin failures++; $display("FAIL post_async_slices0: got %h expected 0000", slc0); end
    checks++; if (mm0 !== 1'b0) begin failures++; $display("FAIL post_async_mismatch0: got %b expected 0", mm0); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_preload();
    test_wrap_saturate();
    test_mismatch();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
